pong_ball_ctrl: RTL and testbench
=================================

PONG_BALL_CTRL -- requirements
Module: pong_ball_ctrl

Interface
REQ-001 The parameter WIN_SCORE SHALL default to 5 and set the points needed to win (range 1..15).
REQ-002 clk  input  1  system clock, rising-edge active; the block SHALL use this one clock only.
REQ-003 rst  input  1  reset, asynchronous and active-low; 0 clears all state immediately.
REQ-004 start  input  1  level input; begins a game when sampled high in IDLE or OVER.
REQ-005 tick  input  1  game-step pulse, one clk wide; a level held high counts as one tick per cycle.
REQ-006 btn_l, btn_r  input  1 each  paddle buttons for player L (bit 0 end) and player R (bit 7 end), synchronous, active-high.
REQ-007 side  output  1  shift direction to the 8-bit LED shift register: 1 = bit0 toward bit7, 0 = bit7 toward bit0.
REQ-008 data  output  1  serial bit injected by the shift register at its entry end.
REQ-009 shift_stb  output  1  one-cycle pulse that clocks the LED shift register.
REQ-010 ball_pos  output  3  current ball column, 0..7.
REQ-011 score_l, score_r  output  4 each  points won by each player.
REQ-012 game_over  output  1  high while in state OVER.

Function
REQ-013 The FSM SHALL have the states IDLE, SERVE, MOVE_UP, MOVE_DN, POINT and OVER.
REQ-014 IDLE or OVER with start=1: clear both scores, set server to L, go to SERVE; a tick in the same cycle SHALL be ignored.
REQ-015 start SHALL be ignored in SERVE, MOVE_UP, MOVE_DN and POINT.
REQ-016 Step timing: a tick accepted at edge T updates side and data at edge T+1; shift_stb is high for exactly the cycle between edges T+1 and T+2; ball_pos, state and scores update at edge T+1.
REQ-017 side and data SHALL hold stable from their update until the next step, so the register never sees them change on a strobe edge.
REQ-018 No new tick SHALL be accepted while a strobe is pending; ticks arriving in that cycle SHALL be dropped.
REQ-019 SERVE with server L, on tick: side=1, data=1, ball_pos=0, go to MOVE_UP.
REQ-020 SERVE with server R, on tick: side=0, data=1, ball_pos=7, go to MOVE_DN.
REQ-021 MOVE_UP, on tick with ball_pos<7: side=1, data=0, ball_pos+1.
REQ-022 MOVE_DN, on tick with ball_pos>0: side=0, data=0, ball_pos-1.
REQ-023 Hit flags: hit_r SHALL set when btn_r=1 while ball_pos=7 in MOVE_UP, and hit_l when btn_l=1 while ball_pos=0 in MOVE_DN; both flags clear whenever ball_pos changes or the state leaves MOVE_*; presses at other times SHALL be ignored.
REQ-024 MOVE_UP, on tick with ball_pos=7 and hit_r set (or btn_r=1 in the tick cycle): side=0, data=0, ball_pos=6, go to MOVE_DN.
REQ-025 MOVE_UP, on tick with ball_pos=7 and no hit: side=1, data=0 (ball shifts out), score_l+1, server set to R, go to POINT; ball_pos holds.
REQ-026 MOVE_DN at ball_pos=0 SHALL mirror REQ-024/025 with btn_l/hit_l, giving ball_pos=1 on a hit, or score_r+1 and server set to L on a miss.
REQ-027 POINT, on the next tick: if either score = WIN_SCORE go to OVER, else go to SERVE; no strobe is issued.
REQ-028 Scores SHALL never exceed WIN_SCORE and SHALL change only in REQ-014, REQ-025 and REQ-026.
REQ-029 OVER SHALL hold scores and assert game_over until start.

Reset
REQ-030 With rst=0: state=IDLE, side=0, data=0, shift_stb=0, ball_pos=0, scores=0, game_over=0, server=L, hit flags and strobe-pending cleared, all regardless of clk.
REQ-031 Release of rst SHALL produce no spurious shift_stb; a reset mid-step SHALL cancel the pending strobe.

Verification
REQ-032 rst, then start, then 1 tick -> one shift_stb two cycles after the tick, with side=1, data=1, ball_pos=0.
REQ-033 After serve, 7 ticks, then btn_r pulse at ball_pos=7, then tick -> side=0, ball_pos=6, state MOVE_DN, scores unchanged.
REQ-034 At ball_pos=7 with no btn_r, tick -> strobe with side=1, data=0; score_l=1; next tick goes to SERVE with server R; next tick gives data=1, side=0, ball_pos=7.
REQ-035 btn_r pressed at ball_pos=5 only, ball reaches 7, tick -> miss scored (an early press is not latched).
REQ-036 L wins 5 rallies -> game_over=1, score_l=5; further ticks produce no strobes; start -> scores 0, game_over=0.
REQ-037 rst asserted between tick and strobe -> no strobe, all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/pong_ball_ctrl_if.sv
// Signal bundle between the pong ball controller and its environment:
// game inputs (start, tick, paddles) and the LED shift-register / score outputs.
interface pong_ball_ctrl_if;
    logic       start;
    logic       tick;
    logic       btn_l;
    logic       btn_r;
    logic       side;
    logic       data;
    logic       shift_stb;
    logic [2:0] ball_pos;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    modport master (
        output start, tick, btn_l, btn_r,
        input  side, data, shift_stb, ball_pos, score_l, score_r, game_over
    );

    modport slave (
        input  start, tick, btn_l, btn_r,
        output side, data, shift_stb, ball_pos, score_l, score_r, game_over
    );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: moves a single lit LED along an 8-bit shift register,
// handles paddle hits and misses, keeps score and declares the winner.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, waiting for start
// SERVE    | next tick launches the ball from the current server's end
// MOVE_UP  | ball travelling from bit0 toward bit7 (player R must return)
// MOVE_DN  | ball travelling from bit7 toward bit0 (player L must return)
// POINT    | a point was just scored; next tick serves again or ends game
// OVER     | someone reached WIN_SCORE; scores frozen until start
module pong_ball_ctrl #(
    parameter int unsigned WIN_SCORE = 5
) (
    input logic            clk,
    input logic            rst,
    pong_ball_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_MOVE_UP,
        ST_MOVE_DN,
        ST_POINT,
        ST_OVER
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic       server_q, server_d;       // 0 = player L serves, 1 = player R
    logic       hit_l_q, hit_l_d;
    logic       hit_r_q, hit_r_d;
    logic       tick_q, tick_d;           // accepted tick, step executes next edge
    logic       shift_stb_q, shift_stb_d;
    logic       side_q, side_d;
    logic       data_q, data_d;
    logic [2:0] pos_q, pos_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       game_over_q, game_over_d;
    logic       playing;

    always_comb begin
        state_d     = state_q;
        server_d    = server_q;
        side_d      = side_q;
        data_d      = data_q;
        pos_d       = pos_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        shift_stb_d = 1'b0;

        playing = (state_q == ST_SERVE) || (state_q == ST_MOVE_UP) ||
                  (state_q == ST_MOVE_DN) || (state_q == ST_POINT);
        // A tick is held off until the previous step's strobe has completed
        tick_d  = bus.tick && playing && !tick_q && !shift_stb_q;

        hit_r_d = (state_q == ST_MOVE_UP) && (pos_q == 3'd7) && (hit_r_q || bus.btn_r);
        hit_l_d = (state_q == ST_MOVE_DN) && (pos_q == 3'd0) && (hit_l_q || bus.btn_l);

        if (((state_q == ST_IDLE) || (state_q == ST_OVER)) && bus.start) begin
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            server_d  = 1'b0;
            state_d   = ST_SERVE;
        end else if (tick_q) begin
            hit_l_d = 1'b0;
            hit_r_d = 1'b0;
            case (state_q)
                ST_SERVE: begin
                    shift_stb_d = 1'b1;
                    data_d      = 1'b1;
                    if (server_q) begin
                        side_d  = 1'b0;
                        pos_d   = 3'd7;
                        state_d = ST_MOVE_DN;
                    end else begin
                        side_d  = 1'b1;
                        pos_d   = 3'd0;
                        state_d = ST_MOVE_UP;
                    end
                end
                ST_MOVE_UP: begin
                    shift_stb_d = 1'b1;
                    data_d      = 1'b0;
                    if (pos_q != 3'd7) begin
                        side_d = 1'b1;
                        pos_d  = pos_q + 3'd1;
                    end else if (hit_r_q || bus.btn_r) begin
                        side_d  = 1'b0;
                        pos_d   = 3'd6;
                        state_d = ST_MOVE_DN;
                    end else begin
                        side_d    = 1'b1;
                        score_l_d = (score_l_q < WIN) ? score_l_q + 4'd1 : score_l_q;
                        server_d  = 1'b1;
                        state_d   = ST_POINT;
                    end
                end
                ST_MOVE_DN: begin
                    shift_stb_d = 1'b1;
                    data_d      = 1'b0;
                    if (pos_q != 3'd0) begin
                        side_d = 1'b0;
                        pos_d  = pos_q - 3'd1;
                    end else if (hit_l_q || bus.btn_l) begin
                        side_d  = 1'b1;
                        pos_d   = 3'd1;
                        state_d = ST_MOVE_UP;
                    end else begin
                        side_d    = 1'b0;
                        score_r_d = (score_r_q < WIN) ? score_r_q + 4'd1 : score_r_q;
                        server_d  = 1'b0;
                        state_d   = ST_POINT;
                    end
                end
                ST_POINT: begin
                    state_d = ((score_l_q == WIN) || (score_r_q == WIN)) ? ST_OVER : ST_SERVE;
                end
                default: begin
                end
            endcase
        end

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            server_q    <= 1'b0;
            hit_l_q     <= 1'b0;
            hit_r_q     <= 1'b0;
            tick_q      <= 1'b0;
            shift_stb_q <= 1'b0;
            side_q      <= 1'b0;
            data_q      <= 1'b0;
            pos_q       <= 3'd0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            server_q    <= server_d;
            hit_l_q     <= hit_l_d;
            hit_r_q     <= hit_r_d;
            tick_q      <= tick_d;
            shift_stb_q <= shift_stb_d;
            side_q      <= side_d;
            data_q      <= data_d;
            pos_q       <= pos_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.side      = side_q;
    assign bus.data      = data_q;
    assign bus.shift_stb = shift_stb_q;
    assign bus.ball_pos  = pos_q;
    assign bus.score_l   = score_l_q;
    assign bus.score_r   = score_r_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Self-checking bench for pong_ball_ctrl: directed scenarios plus random play,
// all compared against a rally-level model of the game.
module tb_pong_ball_ctrl;

    localparam int WIN = 5;
    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_POINT = 3;
    localparam int PH_OVER  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    pong_ball_ctrl_if bus ();

    pong_ball_ctrl #(.WIN_SCORE(WIN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int stb_count = 0;

    always @(negedge clk) if (bus.shift_stb === 1'b1) stb_count++;

    // Game model: ball position and travel direction (+1 toward bit7, -1 toward bit0)
    int m_phase, m_pos, m_dir, m_server, m_sl, m_sr, m_hit;
    bit m_side, m_data;

    task automatic model_reset();
        m_phase = PH_IDLE; m_pos = 0; m_dir = 1; m_server = 0;
        m_sl = 0; m_sr = 0; m_hit = 0; m_side = 0; m_data = 0;
    endtask

    task automatic model_start();
        if (m_phase == PH_IDLE || m_phase == PH_OVER) begin
            m_sl = 0; m_sr = 0; m_server = 0; m_phase = PH_SERVE;
        end
    endtask

    task automatic model_press(input bit l, input bit r);
        if (m_phase == PH_PLAY) begin
            if (l && m_dir < 0 && m_pos == 0) m_hit = 1;
            if (r && m_dir > 0 && m_pos == 7) m_hit = 1;
        end
    endtask

    task automatic model_tick(output bit stb);
        bit at_end;
        stb = 0;
        if (m_phase == PH_SERVE) begin
            m_dir = (m_server == 0) ? 1 : -1;
            m_pos = (m_server == 0) ? 0 : 7;
            m_side = (m_dir > 0); m_data = 1; m_phase = PH_PLAY; stb = 1;
        end else if (m_phase == PH_PLAY) begin
            at_end = (m_dir > 0 && m_pos == 7) || (m_dir < 0 && m_pos == 0);
            m_data = 0; stb = 1;
            if (!at_end) begin
                m_pos += m_dir;
            end else if (m_hit != 0) begin
                m_dir = -m_dir; m_pos += m_dir;
            end else begin
                if (m_dir > 0) begin m_sl++; m_server = 1; end
                else begin m_sr++; m_server = 0; end
                m_phase = PH_POINT;
            end
            m_side = (m_dir > 0);
            m_hit = 0;
        end else if (m_phase == PH_POINT) begin
            m_phase = (m_sl == WIN || m_sr == WIN) ? PH_OVER : PH_SERVE;
        end
    endtask

    function automatic logic [14:0] exp_vec(input bit stb);
        return {stb, m_side, m_data, 3'(m_pos), 4'(m_sl), 4'(m_sr), (m_phase == PH_OVER)};
    endfunction

    function automatic logic [14:0] act_vec();
        return {bus.shift_stb, bus.side, bus.data, bus.ball_pos,
                bus.score_l, bus.score_r, bus.game_over};
    endfunction

    task automatic do_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        model_start();
    endtask

    task automatic press(input bit l, input bit r);
        @(negedge clk) begin bus.btn_l = l; bus.btn_r = r; end
        @(negedge clk) begin bus.btn_l = 1'b0; bus.btn_r = 1'b0; end
        model_press(l, r);
    endtask

    // One tick pulse; strobe must appear only in the second cycle after it
    task automatic do_tick();
        bit es;
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        n_checks++;
        if (bus.shift_stb !== 1'b0) begin
            n_errors++; $display("FAIL stb_early: got %b expected 0", bus.shift_stb);
        end
        model_tick(es);
        @(negedge clk);
        n_checks++;
        if (act_vec() !== exp_vec(es)) begin
            n_errors++;
            $display("FAIL step (stb,side,data,pos,sl,sr,go): got %h expected %h", act_vec(), exp_vec(es));
        end
        @(negedge clk);
        n_checks++;
        if (bus.shift_stb !== 1'b0) begin
            n_errors++; $display("FAIL stb_late: got %b expected 0", bus.shift_stb);
        end
    endtask

    task automatic new_game();
        @(negedge clk) rst = 1'b0;
        model_reset();
        @(negedge clk) rst = 1'b1;
        do_start();
    endtask

    task automatic test_reset();
        bus.start = 0; bus.tick = 0; bus.btn_l = 0; bus.btn_r = 0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (act_vec() !== 15'h0) begin
            n_errors++; $display("FAIL reset_values: got %h expected 0", act_vec());
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (stb_count !== 0 || act_vec() !== 15'h0) begin
            n_errors++; $display("FAIL reset_release: got strobes %0d vec %h expected 0 and 0", stb_count, act_vec());
        end
    endtask

    task automatic test_serve();
        int c0;
        // start and tick together: the tick must be ignored
        c0 = stb_count;
        @(negedge clk) begin bus.start = 1'b1; bus.tick = 1'b1; end
        @(negedge clk) begin bus.start = 1'b0; bus.tick = 1'b0; end
        model_start();
        repeat (3) @(negedge clk);
        n_checks++;
        if (stb_count !== c0) begin
            n_errors++; $display("FAIL start_tick_ignored: got %0d strobes expected %0d", stb_count - c0, 0);
        end
        do_tick();
        n_checks++;
        if ({bus.side, bus.data, bus.ball_pos} !== {1'b1, 1'b1, 3'd0} || stb_count !== c0 + 1) begin
            n_errors++;
            $display("FAIL serve_l: got side %b data %b pos %0d strobes %0d expected 1 1 0 1",
                     bus.side, bus.data, bus.ball_pos, stb_count - c0);
        end
    endtask

    task automatic test_rebound();
        repeat (7) do_tick();
        press(1'b0, 1'b1);
        do_tick();
        n_checks++;
        if ({bus.side, bus.ball_pos, bus.score_l, bus.score_r} !== {1'b0, 3'd6, 4'd0, 4'd0}) begin
            n_errors++;
            $display("FAIL rebound_r: got side %b pos %0d sl %0d sr %0d expected 0 6 0 0",
                     bus.side, bus.ball_pos, bus.score_l, bus.score_r);
        end
        do_tick();
        n_checks++;
        if (bus.ball_pos !== 3'd5) begin
            n_errors++; $display("FAIL moving_down: got pos %0d expected 5", bus.ball_pos);
        end
    endtask

    task automatic test_miss();
        new_game();
        repeat (8) do_tick();
        do_tick();
        n_checks++;
        if ({bus.side, bus.data, bus.score_l, bus.ball_pos} !== {1'b1, 1'b0, 4'd1, 3'd7}) begin
            n_errors++;
            $display("FAIL miss_r: got side %b data %b sl %0d pos %0d expected 1 0 1 7",
                     bus.side, bus.data, bus.score_l, bus.ball_pos);
        end
        do_tick();
        do_tick();
        n_checks++;
        if ({bus.side, bus.data, bus.ball_pos} !== {1'b0, 1'b1, 3'd7}) begin
            n_errors++;
            $display("FAIL serve_r: got side %b data %b pos %0d expected 0 1 7", bus.side, bus.data, bus.ball_pos);
        end
    endtask

    task automatic test_early_press();
        new_game();
        repeat (6) do_tick();
        press(1'b0, 1'b1);
        repeat (3) do_tick();
        n_checks++;
        if ({bus.score_l, bus.side} !== {4'd1, 1'b1}) begin
            n_errors++; $display("FAIL early_press: got sl %0d side %b expected 1 1", bus.score_l, bus.side);
        end
    endtask

    task automatic test_win();
        int c0;
        new_game();
        for (int i = 0; i < 400 && m_phase != PH_OVER; i++) begin
            if (m_phase == PH_PLAY && m_dir < 0 && m_pos == 0) press(1'b1, 1'b0);
            do_tick();
        end
        n_checks++;
        if ({bus.game_over, bus.score_l, bus.score_r} !== {1'b1, 4'd5, 4'd0}) begin
            n_errors++;
            $display("FAIL win_l: got go %b sl %0d sr %0d expected 1 5 0", bus.game_over, bus.score_l, bus.score_r);
        end
        c0 = stb_count;
        repeat (3) do_tick();
        n_checks++;
        if (stb_count !== c0 || bus.game_over !== 1'b1) begin
            n_errors++; $display("FAIL over_hold: got %0d strobes go %b expected 0 1", stb_count - c0, bus.game_over);
        end
        do_start();
        n_checks++;
        if ({bus.game_over, bus.score_l, bus.score_r} !== 9'd0) begin
            n_errors++;
            $display("FAIL restart: got go %b sl %0d sr %0d expected 0 0 0", bus.game_over, bus.score_l, bus.score_r);
        end
    endtask

    task automatic test_back_to_back();
        bit es, prev;
        int n_stb;
        new_game();
        prev = 0; n_stb = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.tick = (c < 9);
            if (bus.shift_stb === 1'b1) begin
                n_stb++;
                model_tick(es);
                n_checks++;
                if (act_vec() !== exp_vec(es) || prev) begin
                    n_errors++;
                    $display("FAIL held_tick_step: got %h prev_stb %b expected %h prev_stb 0", act_vec(), prev, exp_vec(es));
                end
            end
            prev = bus.shift_stb;
        end
        bus.tick = 1'b0;
        n_checks++;
        if (n_stb < 2 || n_stb > 4) begin
            n_errors++; $display("FAIL held_tick_count: got %0d strobes expected 2..4", n_stb);
        end
    endtask

    task automatic test_reset_mid_step();
        int c0;
        new_game();
        do_tick();
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        c0 = stb_count;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (act_vec() !== 15'h0) begin
            n_errors++; $display("FAIL reset_async: got %h expected 0", act_vec());
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (stb_count !== c0) begin
            n_errors++; $display("FAIL reset_cancel: got %0d strobes expected 0", stb_count - c0);
        end
    endtask

    task automatic test_random();
        int r;
        bit at_end;
        new_game();
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            at_end = (m_phase == PH_PLAY) && ((m_dir > 0 && m_pos == 7) || (m_dir < 0 && m_pos == 0));
            if (m_phase == PH_OVER || m_phase == PH_IDLE || r < 4) do_start();
            else if (at_end && r < 60) press(m_dir < 0, m_dir > 0);
            else if (r < 20) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else do_tick();
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_rebound();
        test_miss();
        test_early_press();
        test_win();
        test_back_to_back();
        test_reset_mid_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
